mmio_port_responder: RTL and testbench
======================================

# mmio_port_responder

Memory-mapped I/O responder on the processor's data-memory bus (Address/WriteData/MemWrite/MemRead/ReadData). The processor initiates loads and stores; this block answers those inside a fixed 32-byte window. It owns the 32-bit output port register and synchronizes the 8-bit input port. It also latches per-bit input changes as sticky status with an interrupt line, and provides a free-running tick counter. The top level muxes `ReadData` between this block and data RAM using `Hit`.

## Interface
- `BASE_ADDR`, default 32'h1001_0400: byte address of the window; must be 32-byte aligned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the `clk` rising edge.
- `Address`  in  32: byte address from the ALU result.
- `WriteData`  in  32: store data (register rt).
- `MemWrite`  in  1: store strobe, one cycle per store.
- `MemRead`  in  1: load strobe.
- `PortIn`  in  8: asynchronous external input pins.
- `ReadData`  out  32: load data, combinational from the current register state.
- `Hit`  out  1: combinational; 1 when `Address[31:5] == BASE_ADDR[31:5]`.
- `PortOut`  out  32: registered output port.
- `IrqChange`  out  1: registered; `|(IN_CHANGE & IRQ_MASK)`.

## Operation
- Register map, by byte offset `Address[4:0]`:
  - 0x00 `PORT_OUT`: RW, 32 bits; drives `PortOut`.
  - 0x04 `PORT_IN`: RO; `{24'b0, sync2}`.
  - 0x08 `IN_CHANGE`: RW1C, 8 bits; sticky change flags.
  - 0x0C `IRQ_MASK`: RW, 8 bits.
  - 0x10 `TICK`: RW, 32 bits; +1 every cycle.
  - 0x14–0x1C: reserved. Reads return 0; writes are ignored.
- Write conditions:
  - A write occurs when `MemWrite & Hit & Address[1:0]==0`.
  - Writes with a misaligned address (`Address[1:0] != 0`) are ignored.
  - Reads with a misaligned address return 0.
- `ReadData` is 0 when `Hit=0` or `MemRead=0`.
  - With `MemRead=1` and `Hit=1`, `ReadData` returns the register value held before the current edge.
- `MemRead` and `MemWrite` high together: the write is performed and `ReadData` shows the pre-write value.
- Writes to an 8-bit register (`IN_CHANGE`, `IRQ_MASK`) use `WriteData[7:0]`. Reads zero-extend to 32 bits.
- RO writes (`PORT_IN`) are ignored.
- Input path:
  - Flop chain `sync1 <= PortIn`, `sync2 <= sync1`, `prev <= sync2`.
  - `IN_CHANGE[i]` sets on any edge where `sync2[i] != prev[i]`. Both rising and falling changes set the flag.
- `IN_CHANGE` update per edge: `(IN_CHANGE & ~w1c) | change`, where `w1c` is `WriteData[7:0]` on a valid write to 0x08 and 0 otherwise.
  - A new change wins over a simultaneous clear of the same bit.
- `TICK` update:
  - Without a valid write to 0x10: `TICK <= TICK + 1`, wrapping 32'hFFFF_FFFF → 0.
  - With a valid write to 0x10: `TICK <= WriteData`; that cycle's increment is dropped.
- `IrqChange` is registered from the next-state values of `IN_CHANGE` and `IRQ_MASK`. It therefore reflects the same edge's updates.

## Timing
- Reset (`reset=0` at an edge) clears `PortOut`, `sync1`, `sync2`, `prev`, `IN_CHANGE`, `IRQ_MASK`, `TICK` and `IrqChange`.
  - Reset has priority over any simultaneous write.
  - After reset, reads of all registers return 0.
- Reset mid-operation: the bus write in that cycle is lost. `TICK` restarts from 0 and counts 1 on the first edge with `reset=1`.
- Store latency: a store at edge n makes the new `PortOut` visible immediately after edge n, and it is readable back in cycle n+1.
- `PortIn` latency:
  - A `PortIn` change set up before edge k reaches `PORT_IN` after edge k+1.
  - The matching `IN_CHANGE` bit and `IrqChange` (if the bit is masked in) set after edge k+2.
- An input pulse shorter than one clock may be missed. This is not an error.
- A toggle and back within two cycles sets the flag twice; the flag stays set.
- `ReadData` and `Hit` are purely combinational, with no wait states. They meet single-cycle load timing together with data RAM.

## Test plan
- Reset, then release and idle 3 cycles:
  - `PortOut=0`, `IrqChange=0`, `IN_CHANGE` reads 0.
  - `TICK` reads 2 in the third idle cycle, i.e. 0, 1, 2 across the first three cycles.
- Store 32'hDEAD_BEEF to `BASE+0x00`:
  - `PortOut=DEADBEEF` after that edge and reads back.
  - A store to `BASE+0x01` leaves it unchanged.
  - A store to `BASE+0x20` gives `Hit=0` and no change.
- `IRQ_MASK=0x01`, then `PortIn` 0x00→0x05 at edge k:
  - `PORT_IN` reads 0x05 after edge k+1.
  - `IN_CHANGE=0x05` and `IrqChange=1` after edge k+2.
  - Writing 0x01 to 0x08 leaves `IN_CHANGE=0x04` and drops `IrqChange`.
- W1C of bit 0 in the same cycle that bit 0 sees a new change: bit 0 remains 1.
- `TICK` write 32'hFFFF_FFFE:
  - Reads FFFF_FFFE in the next cycle, then FFFF_FFFF, then 0.
  - A write coinciding with `reset=0` leaves `TICK` at 0.

Source files
------------

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder for a 32-byte window on the data-memory bus:
// output port, synchronized input port with sticky change flags and IRQ, and a tick counter.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut,
  output logic        IrqChange
);

  localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
  localparam logic [2:0] OFF_PORT_IN   = 3'd1;
  localparam logic [2:0] OFF_IN_CHANGE = 3'd2;
  localparam logic [2:0] OFF_IRQ_MASK  = 3'd3;
  localparam logic [2:0] OFF_TICK      = 3'd4;

  logic [31:0] r_port_out;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_prev;
  logic [7:0]  r_in_change;
  logic [7:0]  r_irq_mask;
  logic [31:0] r_tick;
  logic        r_irq;

  logic        w_hit;
  logic        w_aligned;
  logic        w_wr;
  logic [2:0]  w_word;
  logic        w_wr_out;
  logic        w_wr_chg;
  logic        w_wr_mask;
  logic        w_wr_tick;
  logic [7:0]  w_change;
  logic [7:0]  w_w1c;
  logic [7:0]  w_chg_nxt;
  logic [7:0]  w_mask_nxt;
  logic [31:0] w_tick_nxt;

  assign w_hit     = (Address[31:5] == BASE_ADDR[31:5]);
  assign w_aligned = (Address[1:0] == 2'b00);
  assign w_word    = Address[4:2];
  assign w_wr      = MemWrite & w_hit & w_aligned;

  assign w_wr_out  = w_wr && (w_word == OFF_PORT_OUT);
  assign w_wr_chg  = w_wr && (w_word == OFF_IN_CHANGE);
  assign w_wr_mask = w_wr && (w_word == OFF_IRQ_MASK);
  assign w_wr_tick = w_wr && (w_word == OFF_TICK);

  // Clear is applied before OR-ing in new changes so a fresh edge beats a same-cycle W1C.
  assign w_change   = r_sync2 ^ r_prev;
  assign w_w1c      = w_wr_chg ? WriteData[7:0] : 8'h00;
  assign w_chg_nxt  = (r_in_change & ~w_w1c) | w_change;
  assign w_mask_nxt = w_wr_mask ? WriteData[7:0] : r_irq_mask;
  assign w_tick_nxt = w_wr_tick ? WriteData : r_tick + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_port_out  <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_prev      <= '0;
      r_in_change <= '0;
      r_irq_mask  <= '0;
      r_tick      <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_out) r_port_out <= WriteData;
      r_sync1     <= PortIn;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_in_change <= w_chg_nxt;
      r_irq_mask  <= w_mask_nxt;
      r_tick      <= w_tick_nxt;
      r_irq       <= |(w_chg_nxt & w_mask_nxt);
    end
  end

  // Read mux shows pre-edge state; misaligned, reserved and idle reads return zero.
  always_comb begin
    ReadData = 32'h0;
    if (MemRead && w_hit && w_aligned) begin
      case (w_word)
        OFF_PORT_OUT:  ReadData = r_port_out;
        OFF_PORT_IN:   ReadData = {24'h0, r_sync2};
        OFF_IN_CHANGE: ReadData = {24'h0, r_in_change};
        OFF_IRQ_MASK:  ReadData = {24'h0, r_irq_mask};
        OFF_TICK:      ReadData = r_tick;
        default:       ReadData = 32'h0;
      endcase
    end
  end

  assign Hit       = w_hit;
  assign PortOut   = r_port_out;
  assign IrqChange = r_irq;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed vector table, corner sequences, and random traffic vs a reference model.
module tb_mmio_port_responder;

  localparam logic [31:0] B = 32'h1001_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] PortOut;
  logic        IrqChange;

  int n_vec  = 0;
  int n_miss = 0;

  mmio_port_responder #(.BASE_ADDR(B)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
    .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .IrqChange(IrqChange)
  );

  always #5 clk = ~clk;

  // Reference model: register values plus a history of PortIn as sampled at recent edges.
  logic [31:0] m_out, m_tick;
  logic [7:0]  m_chg, m_mask;
  logic        m_irq;
  logic [7:0]  m_pin_hist[3];

  function automatic logic m_hit(input logic [31:0] a);
    return a[31:5] == B[31:5];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic mr);
    if (!mr || !m_hit(a) || a[1:0] != 2'b00) return 32'h0;
    case (a[4:0])
      5'h00:   return m_out;
      5'h04:   return {24'h0, m_pin_hist[1]};
      5'h08:   return {24'h0, m_chg};
      5'h0C:   return {24'h0, m_mask};
      5'h10:   return m_tick;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_edge(input logic r, input logic [31:0] a, input logic [31:0] wd,
                        input logic mw, input logic [7:0] p);
    logic       wr;
    logic [7:0] clr;
    if (!r) begin
      m_out = 0; m_tick = 0; m_chg = 0; m_mask = 0; m_irq = 0;
      for (int i = 0; i < 3; i++) m_pin_hist[i] = 8'h00;
      return;
    end
    wr  = mw && m_hit(a) && a[1:0] == 2'b00;
    clr = (wr && a[4:0] == 5'h08) ? wd[7:0] : 8'h00;
    m_chg = (m_chg & ~clr) | (m_pin_hist[1] ^ m_pin_hist[2]);
    if (wr && a[4:0] == 5'h0C) m_mask = wd[7:0];
    if (wr && a[4:0] == 5'h00) m_out = wd;
    m_tick = (wr && a[4:0] == 5'h10) ? wd : m_tick + 1;
    m_irq = |(m_chg & m_mask);
    m_pin_hist[2] = m_pin_hist[1];
    m_pin_hist[1] = m_pin_hist[0];
    m_pin_hist[0] = p;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive, check combinational and registered outputs mid-cycle, then take the edge.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                      input logic mw, input logic mr, input logic [7:0] p,
                      input logic chk, input logic [31:0] e_rd, input logic e_hit,
                      input logic [31:0] e_out, input logic e_irq);
    reset = r; Address = a; WriteData = wd; MemWrite = mw; MemRead = mr; PortIn = p;
    @(negedge clk);
    check("Hit_model", {31'h0, Hit}, {31'h0, m_hit(a)});
    check("ReadData_model", ReadData, m_read(a, mr));
    check("PortOut_model", PortOut, m_out);
    check("IrqChange_model", {31'h0, IrqChange}, {31'h0, m_irq});
    if (chk) begin
      check("ReadData_tbl", ReadData, e_rd);
      check("Hit_tbl", {31'h0, Hit}, {31'h0, e_hit});
      check("PortOut_tbl", PortOut, e_out);
      check("IrqChange_tbl", {31'h0, IrqChange}, {31'h0, e_irq});
    end
    @(posedge clk);
    m_edge(r, a, wd, mw, p);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mw;
    logic        mr;
    logic [7:0]  pin;
    logic [31:0] rd;
    logic        hit;
    logic [31:0] out;
    logic        irq;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                              input logic mr, input logic [7:0] p, input logic [31:0] rd,
                              input logic h, input logic [31:0] o, input logic q);
    vec_t v;
    v.rst = 1'b1; v.addr = a; v.wd = wd; v.mw = mw; v.mr = mr; v.pin = p;
    v.rd = rd; v.hit = h; v.out = o; v.irq = q;
    return v;
  endfunction

  vec_t tbl[26];

  initial begin
    logic [31:0] DB;
    DB = 32'hDEAD_BEEF;
    tbl[0]  = mk(B+32'h10, 0, 0, 1, 8'h00, 32'd0, 1, 0, 0);
    tbl[1]  = mk(B+32'h10, 0, 0, 1, 8'h00, 32'd1, 1, 0, 0);
    tbl[2]  = mk(B+32'h10, 0, 0, 1, 8'h00, 32'd2, 1, 0, 0);
    tbl[3]  = mk(B+32'h08, 0, 0, 1, 8'h00, 32'd0, 1, 0, 0);
    tbl[4]  = mk(B+32'h00, DB, 1, 1, 8'h00, 32'd0, 1, 0, 0);
    tbl[5]  = mk(B+32'h00, 0, 0, 1, 8'h00, DB, 1, DB, 0);
    tbl[6]  = mk(B+32'h01, 32'h1234_5678, 1, 1, 8'h00, 32'd0, 1, DB, 0);
    tbl[7]  = mk(B+32'h20, 32'h0BAD_F00D, 1, 1, 8'h00, 32'd0, 0, DB, 0);
    tbl[8]  = mk(B+32'h00, 0, 0, 1, 8'h00, DB, 1, DB, 0);
    tbl[9]  = mk(B+32'h0C, 32'h0000_0001, 1, 0, 8'h00, 32'd0, 1, DB, 0);
    tbl[10] = mk(B+32'h0C, 0, 0, 1, 8'h05, 32'd1, 1, DB, 0);
    tbl[11] = mk(B+32'h04, 0, 0, 1, 8'h05, 32'd0, 1, DB, 0);
    tbl[12] = mk(B+32'h04, 0, 0, 1, 8'h05, 32'd5, 1, DB, 0);
    tbl[13] = mk(B+32'h08, 32'h0000_0001, 1, 1, 8'h05, 32'd5, 1, DB, 1);
    tbl[14] = mk(B+32'h08, 0, 0, 1, 8'h05, 32'd4, 1, DB, 0);
    tbl[15] = mk(B+32'h08, 0, 0, 1, 8'h04, 32'd4, 1, DB, 0);
    tbl[16] = mk(B+32'h08, 0, 0, 1, 8'h04, 32'd4, 1, DB, 0);
    tbl[17] = mk(B+32'h08, 32'h0000_0001, 1, 1, 8'h04, 32'd4, 1, DB, 0);
    tbl[18] = mk(B+32'h08, 0, 0, 1, 8'h04, 32'd5, 1, DB, 1);
    tbl[19] = mk(B+32'h10, 32'hFFFF_FFFE, 1, 1, 8'h04, 32'd19, 1, DB, 1);
    tbl[20] = mk(B+32'h10, 0, 0, 1, 8'h04, 32'hFFFF_FFFE, 1, DB, 1);
    tbl[21] = mk(B+32'h10, 0, 0, 1, 8'h04, 32'hFFFF_FFFF, 1, DB, 1);
    tbl[22] = mk(B+32'h10, 0, 0, 1, 8'h04, 32'h0000_0000, 1, DB, 1);
    tbl[23] = mk(B+32'h14, 32'hFFFF_FFFF, 1, 1, 8'h04, 32'd0, 1, DB, 1);
    tbl[24] = mk(B+32'h04, 32'h0000_00FF, 1, 1, 8'h04, 32'd4, 1, DB, 1);
    tbl[25] = mk(B+32'h04, 0, 0, 1, 8'h04, 32'd4, 1, DB, 1);

    reset = 1'b0; Address = 0; WriteData = 0; MemWrite = 0; MemRead = 0; PortIn = 0;
    repeat (2) @(posedge clk);
    m_edge(1'b0, 0, 0, 1'b0, 8'h00);
    #1;

    for (int i = 0; i < 26; i++)
      step(tbl[i].rst, tbl[i].addr, tbl[i].wd, tbl[i].mw, tbl[i].mr, tbl[i].pin,
           1'b1, tbl[i].rd, tbl[i].hit, tbl[i].out, tbl[i].irq);

    // Reset coinciding with a TICK write and a PORT_OUT-visible state: reset wins, tick restarts.
    step(1'b0, B+32'h10, 32'h5555_5555, 1'b1, 1'b1, 8'h04, 1'b0, 0, 0, 0, 0);
    step(1'b1, B+32'h10, 32'h0, 1'b0, 1'b1, 8'h04, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0);
    step(1'b1, B+32'h10, 32'h0, 1'b0, 1'b1, 8'h04, 1'b1, 32'd1, 1'b1, 32'd0, 1'b0);
    step(1'b1, B+32'h0C, 32'h0, 1'b0, 1'b1, 8'h04, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0);

    // Random traffic, mostly inside the window, with occasional resets and input changes.
    begin
      logic [7:0]  pin;
      logic [31:0] a;
      logic        r;
      pin = 8'h04;
      for (int i = 0; i < 600; i++) begin
        r = ($urandom_range(0, 63) != 0);
        case ($urandom_range(0, 9))
          0:       a = B + $urandom_range(0, 31);
          1:       a = B + 32'h20 + ($urandom_range(0, 7) << 2);
          2:       a = $urandom;
          default: a = B + ($urandom_range(0, 7) << 2);
        endcase
        if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
        step(r, a, $urandom, 1'($urandom), 1'($urandom), pin, 1'b0, 0, 0, 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
